// File: rtl/rd_wr_responder.sv
// rd_wr_responder: target-side register file for the start/wr/rd strobe bus.
// It also supervises each session: after a start edge it expects one write,
// then a read, within TIMEOUT cycles per wait state. Collisions and timeouts
// are reported through sticky status bits.
// Optional build macro: RD_BURST2_EN, which requires two back-to-back
// read-only cycles to complete a session.
module rd_wr_responder #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              done,
  output logic              err_collision,
  output logic              err_timeout
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

`ifdef RD_BURST2_EN
  localparam bit BURST2 = 1'b1;
`else
  localparam bit BURST2 = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_WR = 3'd1,
    WAIT_RD = 3'd2,
    DONE    = 3'd3,
    ERR     = 3'd4
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               start_q;
  logic               rd_pend;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic start_rise_c;
  logic wr_only_c;
  logic rd_only_c;
  logic coll_c;
  logic rd_complete_c;
  logic cnt_expired_c;

  // Strobe decode shared by storage and session tracking.
  always_comb begin
    start_rise_c  = start & ~start_q;
    wr_only_c     = wr & ~rd;
    rd_only_c     = rd & ~wr;
    coll_c        = wr & rd;
    rd_complete_c = rd_only_c & (~BURST2 | rd_pend);
    cnt_expired_c = (cnt == CNT_LAST);
  end

  // Start edge history.
  always_ff @(posedge clk) begin
    if (rst) start_q <= 1'b0;
    else     start_q <= start;
  end

  // Storage: writes on write-only cycles, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (wr_only_c) begin
      mem[addr] <= wdata;
    end
  end

  // Read port: one-cycle latency, rdata holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_only_c;
      if (rd_only_c) rdata <= mem[addr];
    end
  end

  // Session FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      rd_pend       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_collision <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      // Set wins over the clear that a start edge applies below.
      if (coll_c) err_collision <= 1'b1;

      if (start_rise_c) begin
        state       <= WAIT_WR;
        cnt         <= '0;
        rd_pend     <= 1'b0;
        busy        <= 1'b1;
        done        <= 1'b0;
        err_timeout <= 1'b0;
        if (!coll_c) err_collision <= 1'b0;
      end else begin
        case (state)
          WAIT_WR: begin
            if (coll_c) begin
              state <= ERR;
              busy  <= 1'b0;
              cnt   <= '0;
            end else if (wr_only_c) begin
              state   <= WAIT_RD;
              cnt     <= '0;
              rd_pend <= 1'b0;
            end else if (cnt_expired_c) begin
              state       <= ERR;
              busy        <= 1'b0;
              cnt         <= '0;
              err_timeout <= 1'b1;
            end else if (cnt != CNT_MAX) begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          WAIT_RD: begin
            if (coll_c) begin
              state   <= ERR;
              busy    <= 1'b0;
              cnt     <= '0;
              rd_pend <= 1'b0;
            end else if (rd_complete_c) begin
              state   <= DONE;
              busy    <= 1'b0;
              cnt     <= '0;
              rd_pend <= 1'b0;
              done    <= 1'b1;
            end else if (cnt_expired_c) begin
              state       <= ERR;
              busy        <= 1'b0;
              cnt         <= '0;
              rd_pend     <= 1'b0;
              err_timeout <= 1'b1;
            end else begin
              // A lone read arms the pair; anything else restarts it.
              rd_pend <= rd_only_c;
              if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rd_wr_responder.sv
// Directed bench for rd_wr_responder with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled on the next falling
// edge, i.e. half a cycle after the rising edge that consumed the inputs.
module tb_rd_wr_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       wr;
  logic       rd;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rvalid;
  logic       busy;
  logic       done;
  logic       err_collision;
  logic       err_timeout;

  int tests_run = 0;
  int tests_failed = 0;

  rd_wr_responder #(.DATA_W(8), .ADDR_W(4), .TIMEOUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .wr            (wr),
    .rd            (rd),
    .addr          (addr),
    .wdata         (wdata),
    .rdata         (rdata),
    .rvalid        (rvalid),
    .busy          (busy),
    .done          (done),
    .err_collision (err_collision),
    .err_timeout   (err_timeout)
  );

  always #5 clk = ~clk;

`ifdef RD_BURST2_EN
  localparam bit BURST2 = 1'b1;
`else
  localparam bit BURST2 = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of strobes; returns after outputs of that edge settle.
  task automatic drive(input logic s, input logic w, input logic r,
                       input logic [3:0] a, input logic [7:0] d);
    start = s; wr = w; rd = r; addr = a; wdata = d;
    @(negedge clk);
    start = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
  endtask

  task automatic check_status(input string tag, input logic b, input logic dn,
                              input logic ec, input logic et);
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_done"}, 32'(done), 32'(dn));
    check({tag, "_ecol"}, 32'(err_collision), 32'(ec));
    check({tag, "_eto"},  32'(err_timeout), 32'(et));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check_status("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Basic session: write 0xA5 to addr 3, read it back twice.
    drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    check("s1_busy_start", 32'(busy), 32'h1);
    drive(1'b0, 1'b1, 1'b0, 4'd3, 8'hA5);
    check("s1_rvalid_wr", 32'(rvalid), 32'h0);
    check("s1_busy_wr", 32'(busy), 32'h1);
    drive(1'b0, 1'b0, 1'b1, 4'd3, 8'h00);
    check("s1_rvalid_r1", 32'(rvalid), 32'h1);
    check("s1_rdata_r1", 32'(rdata), 32'hA5);
    check("s1_done_r1", 32'(done), BURST2 ? 32'h0 : 32'h1);
    drive(1'b0, 1'b0, 1'b1, 4'd3, 8'h00);
    check("s1_rvalid_r2", 32'(rvalid), 32'h1);
    check("s1_rdata_r2", 32'(rdata), 32'hA5);
    check_status("s1_end", 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    check("s1_rvalid_idle", 32'(rvalid), 32'h0);
    check("s1_rdata_hold", 32'(rdata), 32'hA5);

    // Collision in WAIT_WR: no write, no read, ERR.
    drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    check("s2_done_clr", 32'(done), 32'h0);
    drive(1'b0, 1'b1, 1'b1, 4'd2, 8'h11);
    check("s2_rvalid", 32'(rvalid), 32'h0);
    check_status("s2_coll", 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 4'd2, 8'h00);
    check("s2_rd_rvalid", 32'(rvalid), 32'h1);
    check("s2_rd_rdata", 32'(rdata), 32'h00);
    check("s2_ecol_sticky", 32'(err_collision), 32'h1);

    // Timeout: no strobes after start, err_timeout 16 cycles later.
    drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    check_status("s3_start", 1'b1, 1'b0, 1'b0, 1'b0);
    idle(15);
    check_status("s3_pre", 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    check_status("s3_to", 1'b0, 1'b0, 1'b0, 1'b1);

    // DONE, then a fresh start clears status; addr 15 session.
    drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    check("s4_eto_clr", 32'(err_timeout), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 4'd15, 8'h3C);
    drive(1'b0, 1'b0, 1'b1, 4'd15, 8'h00);
    if (BURST2) drive(1'b0, 1'b0, 1'b1, 4'd15, 8'h00);
    check_status("s4_done1", 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    check_status("s4_restart", 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 4'd15, 8'h3C);
    drive(1'b0, 1'b0, 1'b1, 4'd15, 8'h00);
    if (BURST2) drive(1'b0, 1'b0, 1'b1, 4'd15, 8'h00);
    check_status("s4_done2", 1'b0, 1'b1, 1'b0, 1'b0);
    check("s4_rdata", 32'(rdata), 32'h3C);

    // Reads in WAIT_WR are serviced but do not advance the session.
    drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 4'd3, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 4'd3, 8'h00);
    check("s5_rdata", 32'(rdata), 32'hA5);
    check_status("s5_noadv", 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in WAIT_RD coincident with a write: write discarded.
    drive(1'b0, 1'b1, 1'b0, 4'd1, 8'h77);
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 4'd1, 8'h55);
    rst = 1'b0;
    check("s6_rdata", 32'(rdata), 32'h0);
    check("s6_rvalid", 32'(rvalid), 32'h0);
    check_status("s6_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 4'd1, 8'h00);
    check("s6_rd1_rvalid", 32'(rvalid), 32'h1);
    check("s6_rd1_rdata", 32'(rdata), 32'h00);
    drive(1'b0, 1'b0, 1'b1, 4'd15, 8'h00);
    check("s6_rd15_rdata", 32'(rdata), 32'h00);

    // Single read then idle: completes only in the default build.
    drive(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 4'd6, 8'h5A);
    drive(1'b0, 1'b0, 1'b1, 4'd6, 8'h00);
    check("s7_rdata", 32'(rdata), 32'h5A);
    idle(1);
    check("s7_done_single", 32'(done), BURST2 ? 32'h0 : 32'h1);
    check("s7_busy_single", 32'(busy), BURST2 ? 32'h1 : 32'h0);
    drive(1'b0, 1'b0, 1'b1, 4'd6, 8'h00);
    check("s7_done_b1", 32'(done), BURST2 ? 32'h0 : 32'h1);
    drive(1'b0, 1'b0, 1'b1, 4'd6, 8'h00);
    check_status("s7_done_b2", 1'b0, 1'b1, 1'b0, 1'b0);

    // Collision in IDLE-like DONE state, and start plus collision together.
    drive(1'b0, 1'b1, 1'b1, 4'd0, 8'hFF);
    check("s8_ecol_done", 32'(err_collision), 32'h1);
    check("s8_done_hold", 32'(done), 32'h1);
    drive(1'b1, 1'b1, 1'b1, 4'd0, 8'hFF);
    check_status("s8_start_coll", 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
    check("s8_rdata0", 32'(rdata), 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
